// File: rtl/pe_fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_fp_pkg
// Description : Shared floating-point format definitions for the PE
//               accumulate path (alignment front end and normalize back end).
// Revision    : 1.0 - initial release
// ============================================================================
package pe_fp_pkg;

  // Default packed-result geometry
  localparam int PE_EXP_W  = 8;
  localparam int PE_FRAC_W = 7;

  // Special exponent encodings
  localparam logic [PE_EXP_W-1:0] PE_EXP_ZERO = '0;
  localparam logic [PE_EXP_W-1:0] PE_EXP_ONES = '1;

  // Packed floating-point result {sign, biased exponent, stored fraction}
  typedef struct packed {
    logic                 sign;
    logic [PE_EXP_W-1:0]  exp;
    logic [PE_FRAC_W-1:0] frac;
  } fp_res_t;

endpackage : pe_fp_pkg
`default_nettype wire

// File: rtl/lead_one_detect.sv
`default_nettype none
// ============================================================================
// Module      : lead_one_detect
// Description : Combinational leading-one detector. Returns the bit index of
//               the most significant set bit and a flag for an all-zero input.
// Revision    : 1.0 - initial release
// ============================================================================
module lead_one_detect #(
  parameter int W = 24
) (
  input  logic [W-1:0]         vec_i,
  output logic [$clog2(W)-1:0] pos_o,
  output logic                 zero_o
);

  localparam int P_W = $clog2(W);

  // Scan upward so the highest set bit is the last one to write the position
  always_comb begin
    pos_o  = '0;
    zero_o = ~|vec_i;
    for (int i = 0; i < W; i++) begin
      if (vec_i[i]) begin
        pos_o = P_W'(i);
      end
    end
  end

endmodule : lead_one_detect
`default_nettype wire

// File: rtl/acc_normalize_pipe.sv
`default_nettype none
// ============================================================================
// Module      : acc_normalize_pipe
// Description : Converts a signed fixed-point accumulator sum plus the shared
//               exponent back into a packed floating-point result.
//               S1: sign / magnitude, S2: leading-one normalize with guard and
//               sticky, S3: round-to-nearest-even, exponent adjust, saturate
//               to infinity or flush to signed zero.
//               Optional macro ACC_NORM_FLAGS_EN adds sticky status flags
//               {overflow, underflow, inexact} with a clear input.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_normalize_pipe
  import pe_fp_pkg::*;
#(
  parameter int EXP_W  = PE_EXP_W,
  parameter int FRAC_W = PE_FRAC_W,
  parameter int SUM_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SUM_W-1:0]  acc_sum,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac
`ifdef ACC_NORM_FLAGS_EN
  ,
  input  logic              flag_clr,
  output logic [2:0]        flags
`endif
);

  localparam int P_W = $clog2(SUM_W);
  localparam int E_W = EXP_W + 2;
  localparam logic signed [E_W-1:0] E_ZERO = '0;
  localparam logic signed [E_W-1:0] E_SAT  = E_W'((1 << EXP_W) - 1);

  // --------------------------------------------------------------------------
  // Handshake chain: each stage may load when empty or when it is draining
  // --------------------------------------------------------------------------
  logic s1_valid_q, s2_valid_q, out_valid_q;
  logic s3_ready, s2_ready, s1_advance, s2_advance, s1_load;

  assign s3_ready   = !out_valid_q | out_ready;
  assign s2_ready   = !s2_valid_q | s3_ready;
  assign s1_advance = s1_valid_q & s2_ready;
  assign s2_advance = s2_valid_q & s3_ready;
  assign in_ready   = !s1_valid_q | s1_advance;
  assign s1_load    = in_valid & in_ready;

  // --------------------------------------------------------------------------
  // S1: split into sign and unsigned magnitude
  // --------------------------------------------------------------------------
  logic             s1_sign_q, s1_sign_d;
  logic [SUM_W-1:0] s1_mag_q,  s1_mag_d;
  logic [EXP_W-1:0] s1_exp_q;

  // Unsigned negation keeps the most negative sum representable as 2^(SUM_W-1)
  always_comb begin
    s1_sign_d = acc_sum[SUM_W-1];
    s1_mag_d  = s1_sign_d ? (-acc_sum) : acc_sum;
  end

  // S1 register: valid follows the input whenever the stage can accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
      s1_exp_q   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (s1_load) begin
        s1_sign_q <= s1_sign_d;
        s1_mag_q  <= s1_mag_d;
        s1_exp_q  <= exp_in;
      end
    end
  end

  // --------------------------------------------------------------------------
  // S2: leading-one detect and normalize
  // --------------------------------------------------------------------------
  logic [P_W-1:0]    lod_pos;
  logic              lod_zero;
  logic [P_W-1:0]    shamt;
  logic [SUM_W-2:0]  norm;

  logic              s2_sign_q, s2_zero_q, s2_guard_q, s2_sticky_q;
  logic [FRAC_W-1:0] s2_frac_q, s2_frac_d;
  logic              s2_guard_d, s2_sticky_d;
  logic signed [E_W-1:0] s2_e_pre_q, s2_e_pre_d;

  lead_one_detect #(
    .W (SUM_W)
  ) u_lod (
    .vec_i  (s1_mag_q),
    .pos_o  (lod_pos),
    .zero_o (lod_zero)
  );

  // Left-justify so the leading one drops off the top; the rest lines up as
  // fraction, guard and sticky whether the value was shifted left or right
  always_comb begin
    shamt       = P_W'(SUM_W - 1) - lod_pos;
    norm        = s1_mag_q[SUM_W-2:0] << shamt;
    s2_frac_d   = norm[SUM_W-2 -: FRAC_W];
    s2_guard_d  = norm[SUM_W-2-FRAC_W];
    s2_sticky_d = |norm[SUM_W-3-FRAC_W:0];
    s2_e_pre_d  = $signed({2'b00, s1_exp_q}) + $signed(E_W'(lod_pos))
                - $signed(E_W'(FRAC_W));
  end

  // S2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_frac_q   <= '0;
      s2_guard_q  <= 1'b0;
      s2_sticky_q <= 1'b0;
      s2_e_pre_q  <= '0;
    end else begin
      if (s2_ready) begin
        s2_valid_q <= s1_valid_q;
      end
      if (s1_advance) begin
        s2_sign_q   <= s1_sign_q;
        s2_zero_q   <= lod_zero;
        s2_frac_q   <= s2_frac_d;
        s2_guard_q  <= s2_guard_d;
        s2_sticky_q <= s2_sticky_d;
        s2_e_pre_q  <= s2_e_pre_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // S3: round, adjust exponent, pack with saturate / flush
  // --------------------------------------------------------------------------
  logic                  round_up;
  logic [FRAC_W:0]       frac_inc;
  logic signed [E_W-1:0] e_fin;
  logic                  is_ovf, is_unf;

  logic              out_sign_q, out_sign_d;
  logic [EXP_W-1:0]  out_exp_q,  out_exp_d;
  logic [FRAC_W-1:0] out_frac_q, out_frac_d;

  // A carry out of the fraction leaves it at zero and bumps the exponent
  always_comb begin
    round_up = s2_guard_q & (s2_sticky_q | s2_frac_q[0]);
    frac_inc = {1'b0, s2_frac_q} + {{FRAC_W{1'b0}}, round_up};
    e_fin    = s2_e_pre_q + $signed({{(E_W-1){1'b0}}, frac_inc[FRAC_W]});
    is_ovf   = !s2_zero_q && (e_fin >= E_SAT);
    is_unf   = !s2_zero_q && (e_fin <= E_ZERO);

    out_sign_d = s2_sign_q;
    out_exp_d  = e_fin[EXP_W-1:0];
    out_frac_d = frac_inc[FRAC_W-1:0];
    if (s2_zero_q) begin
      out_sign_d = 1'b0;
      out_exp_d  = '0;
      out_frac_d = '0;
    end else if (is_unf) begin
      out_exp_d  = '0;
      out_frac_d = '0;
    end else if (is_ovf) begin
      out_exp_d  = '1;
      out_frac_d = '0;
    end
  end

  // Output register holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_frac_q  <= '0;
    end else begin
      if (s3_ready) begin
        out_valid_q <= s2_valid_q;
      end
      if (s2_advance) begin
        out_sign_q <= out_sign_d;
        out_exp_q  <= out_exp_d;
        out_frac_q <= out_frac_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_frac  = out_frac_q;

`ifdef ACC_NORM_FLAGS_EN
  // --------------------------------------------------------------------------
  // Sticky status flags {overflow, underflow, inexact}
  // --------------------------------------------------------------------------
  logic [2:0] beat_flags_q;
  logic [2:0] flags_q, flags_d;

  // Per-beat status travels with the result in the output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_flags_q <= '0;
    end else if (s2_advance) begin
      beat_flags_q <= {is_ovf, is_unf, s2_guard_q | s2_sticky_q};
    end
  end

  // Clear first, then OR in the transferring beat so a coincident set wins
  always_comb begin
    flags_d = flag_clr ? 3'b000 : flags_q;
    if (out_valid_q && out_ready) begin
      flags_d = flags_d | beat_flags_q;
    end
  end

  // Flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;
`else
  // Status flag tracking is compiled out; the datapath is unchanged.
`endif

endmodule : acc_normalize_pipe
`default_nettype wire

// File: tb/tb_acc_normalize_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_normalize_pipe
// Description : Scoreboard bench for acc_normalize_pipe. Directed vectors push
//               hand-computed results into a queue; a monitor compares every
//               presented output against the queue head.
//               Define ACC_NORM_FLAGS_EN to also exercise the status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_normalize_pipe;
  import pe_fp_pkg::*;

  localparam int SUM_W = 24;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [SUM_W-1:0]     acc_sum;
  logic [PE_EXP_W-1:0]  exp_in;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sign;
  logic [PE_EXP_W-1:0]  out_exp;
  logic [PE_FRAC_W-1:0] out_frac;
`ifdef ACC_NORM_FLAGS_EN
  logic                 flag_clr;
  logic [2:0]           flags;
`endif

  int      n_checks   = 0;
  int      n_pass     = 0;
  int      n_accepted = 0;
  fp_res_t exp_q[$];

  always #5 clk = ~clk;

  acc_normalize_pipe #(
    .EXP_W  (PE_EXP_W),
    .FRAC_W (PE_FRAC_W),
    .SUM_W  (SUM_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_sum   (acc_sum),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_frac  (out_frac)
`ifdef ACC_NORM_FLAGS_EN
    ,
    .flag_clr  (flag_clr),
    .flags     (flags)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  function automatic fp_res_t mk(input int s, input int e, input int f);
    fp_res_t r;
    r.sign = s[0];
    r.exp  = PE_EXP_W'(e);
    r.frac = PE_FRAC_W'(f);
    return r;
  endfunction

  // Drive one beat from a negedge, wait for in_ready, log expectation
  task automatic send(input int a, input int e, input fp_res_t r);
    int g = 0;
    @(negedge clk);
    in_valid = 1'b1;
    acc_sum  = SUM_W'(a);
    exp_in   = PE_EXP_W'(e);
    #1;
    while (in_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (in_ready !== 1'b1) begin
      chk("send_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(r);
    @(posedge clk);
    n_accepted++;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_latency();
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (out_valid !== 1'b1 && n < 10);
    chk("latency_cycles", 32'(n), 32'd3);
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compare whatever is presented against the queue head
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          chk("out_sign", 32'(out_sign), 32'(exp_q[0].sign));
          chk("out_exp",  32'(out_exp),  32'(exp_q[0].exp));
          chk("out_frac", 32'(out_frac), 32'(exp_q[0].frac));
          if (out_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not terminate, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    acc_sum   = '0;
    exp_in    = '0;
`ifdef ACC_NORM_FLAGS_EN
    flag_clr  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_sign",  32'(out_sign),  32'd0);
    chk("reset_out_exp",   32'(out_exp),   32'd0);
    chk("reset_out_frac",  32'(out_frac),  32'd0);
`ifdef ACC_NORM_FLAGS_EN
    chk("reset_flags", 32'(flags), 32'd0);
`endif

    // Directed vectors, streamed back to back
    send(128, 100, mk(0, 100, 8'h00));
    check_latency();
    drain();
    send(-128,       100, mk(1, 100, 8'h00));
    send(385,        100, mk(0, 101, 8'h40));  // tie, stays even
    send(387,        100, mk(0, 101, 8'h42));  // round up
    send(511,        100, mk(0, 102, 8'h00));  // rounding carry
    send(0,          100, mk(0,   0, 8'h00));  // zero
    send(1,            3, mk(0,   0, 8'h00));  // flush
    send(-1,           3, mk(1,   0, 8'h00));  // flush to signed zero
    send(1 << 20,    250, mk(0, 255, 8'h00));  // saturate
    send(-(1 << 23), 100, mk(1, 116, 8'h00));  // most negative sum
    send(-1,          10, mk(1,   3, 8'h00));  // left shift, negative
    send(5,           50, mk(0,  45, 8'h20));  // left shift with fraction
    send(32'h1011,   100, mk(0, 105, 8'h01));  // guard + sticky rounds up
    send(32'h1010,   100, mk(0, 105, 8'h00));  // exact tie, even
    send(128,        254, mk(0, 254, 8'h00));  // largest normal exponent
    send(128,        255, mk(0, 255, 8'h00));  // exponent hits all ones
    send(1,            7, mk(0,   0, 8'h00));  // e == 0 flushes
    send(1,            8, mk(0,   1, 8'h00));  // e == 1 normal
    send(511,        253, mk(0, 255, 8'h00));  // carry into saturation
    drain();

    // Backpressure: 5 stalled cycles during a 6-beat burst
    n_accepted = 0;
    fork
      begin
        send(128,  100, mk(0, 100, 8'h00));
        send(-128, 100, mk(1, 100, 8'h00));
        send(385,  100, mk(0, 101, 8'h40));
        send(387,  100, mk(0, 101, 8'h42));
        send(511,  100, mk(0, 102, 8'h00));
        send(5,     50, mk(0,  45, 8'h20));
      end
      begin
        @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("stall_in_ready",    32'(in_ready),   32'd0);
        chk("stall_beats_held",  32'(n_accepted), 32'd3);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("burst_accepted", 32'(n_accepted), 32'd6);

    // Reset with three beats in flight
    send(128, 100, mk(0, 100, 8'h00));
    send(387, 100, mk(0, 101, 8'h42));
    send(511, 100, mk(0, 102, 8'h00));
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_sign",  32'(out_sign),  32'd0);
    chk("midrst_out_exp",   32'(out_exp),   32'd0);
    chk("midrst_out_frac",  32'(out_frac),  32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("post_reset_idle", 32'(out_valid), 32'd0);
    end
    send(128, 100, mk(0, 100, 8'h00));
    check_latency();
    drain();

`ifdef ACC_NORM_FLAGS_EN
    @(negedge clk);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    #1;
    chk("flags_initial_clear", 32'(flags), 32'd0);
    send(1 << 20, 250, mk(0, 255, 8'h00));
    send(387,     100, mk(0, 101, 8'h42));
    drain();
    chk("flags_ovf_inexact", 32'(flags), 32'b101);
    @(negedge clk);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    #1;
    chk("flags_cleared", 32'(flags), 32'd0);
    send(387, 100, mk(0, 101, 8'h42));
    repeat (3) @(negedge clk);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    #1;
    chk("flags_set_wins", 32'(flags), 32'b001);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_acc_normalize_pipe
`default_nettype wire
